modbus_tx_frame_ctrl: RTL and testbench

Sequences one Modbus RTU response frame onto the UART byte transmitter (uart_byte_tx). It fetches payload bytes from a slave-side frame buffer and hands each byte to the transmitter with the start/done handshake. It computes CRC-16/Modbus on the fly, appends the CRC low byte then high byte, then enforces the t3.5 silent interval before reporting completion. It sits between the Modbus response builder and the UART TX pin driver.

---
 rtl/modbus_tx_frame_ctrl_pkg.sv | 38 +++
 rtl/modbus_tx_frame_ctrl_crc16_modbus_byte.sv | 45 ++++
 rtl/modbus_tx_frame_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_modbus_tx_frame_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/modbus_tx_frame_ctrl_pkg.sv
// Shared definitions for the Modbus RTU transmit path: FSM encodings, CRC-16/Modbus
// constants and the silent-interval / watchdog derivations.
package modbus_tx_frame_ctrl_pkg;

  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StWait,
    StCrcLo,
    StCrcHi,
    StGap
  } tx_state_e;

  typedef enum logic [1:0] {
    SelData,
    SelCrcLo,
    SelCrcHi
  } tx_sel_e;

  // Above 19200 baud the t3.5 interval is fixed at 1.75 ms.
  function automatic int unsigned gap_clks(int unsigned clk_freq, int unsigned baud,
                                           int unsigned bps);
    if (baud > 19200) begin
      return clk_freq / 1000 * 7 / 4;
    end
    return bps * 39;
  endfunction

  function automatic int unsigned tmo_clks(int unsigned bps);
    return bps * 12 + 16;
  endfunction

endpackage

// File: rtl/modbus_tx_frame_ctrl_crc16_modbus_byte.sv
// Bit-serial CRC-16/Modbus engine: one data byte absorbed per start, 8 cycles per byte.
module crc16_modbus_byte
  import modbus_tx_frame_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        init,
  input  logic        start,
  input  logic [7:0]  din,
  output logic        busy,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    crc_d = crc_q;
    cnt_d = cnt_q;
    if (init) begin
      crc_d = CRC16_INIT;
      cnt_d = 4'd0;
    end else if (start) begin
      crc_d = crc_q ^ {8'h00, din};
      cnt_d = 4'd8;
    end else if (cnt_q != 4'd0) begin
      crc_d = crc_q[0] ? ((crc_q >> 1) ^ CRC16_POLY) : (crc_q >> 1);
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      crc_q <= CRC16_INIT;
      cnt_q <= 4'd0;
    end else begin
      crc_q <= crc_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != 4'd0);
  assign crc  = crc_q;

endmodule

// File: rtl/modbus_tx_frame_ctrl.sv
// Sequences one Modbus RTU response frame (payload, CRC lo, CRC hi, t3.5 gap) onto the
// UART byte transmitter with a per-byte tx_done watchdog.
module modbus_tx_frame_ctrl
  import modbus_tx_frame_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        frame_start,
  input  logic [7:0]  frame_len,
  output logic [7:0]  buf_rd_addr,
  input  logic [7:0]  buf_rd_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] crc_out
);

  localparam int unsigned BPS_PARAM = CLK_FREQ / BAUD_RATE;
  localparam int unsigned GAP_CLKS  = gap_clks(CLK_FREQ, BAUD_RATE, BPS_PARAM);
  localparam int unsigned TMO_CLKS  = tmo_clks(BPS_PARAM);
  localparam logic [31:0] GapLast   = 32'(GAP_CLKS - 1);
  localparam logic [31:0] TmoLast   = 32'(TMO_CLKS - 1);

  tx_state_e   state_q, state_d;
  tx_sel_e     sel_q, sel_d;
  logic [7:0]  len_q, len_d, idx_q, idx_d, addr_q, addr_d, tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [15:0] crc_out_q, crc_out_d;
  logic [31:0] cnt_q, cnt_d;

  logic        crc_init, crc_start, crc_busy;
  logic [15:0] crc_val;

  crc16_modbus_byte u_crc (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .init     (crc_init),
    .start    (crc_start),
    .din      (buf_rd_data),
    .busy     (crc_busy),
    .crc      (crc_val)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    len_d      = len_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    crc_out_d  = crc_out_q;
    cnt_d      = cnt_q;
    crc_init   = 1'b0;
    crc_start  = 1'b0;

    case (state_q)
      StIdle: begin
        if (frame_start && (frame_len != 8'd0)) begin
          len_d    = frame_len;
          idx_d    = 8'd0;
          addr_d   = 8'd0;
          sel_d    = SelData;
          busy_d   = 1'b1;
          crc_init = 1'b1;
          state_d  = StFetch;
        end
      end
      // Address was driven on entry; buffer data becomes valid one cycle later.
      StFetch: state_d = StLoad;
      StLoad: begin
        tx_data_d  = buf_rd_data;
        crc_start  = 1'b1;
        tx_start_d = 1'b1;
        cnt_d      = 32'd0;
        state_d    = StStart;
      end
      // cnt_q doubles as the watchdog: cleared at the tx_start rise, counts through WAIT.
      StStart: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'd1) begin
          tx_start_d = 1'b0;
          state_d    = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 32'd1;
        if (tx_done) begin
          case (sel_q)
            SelData: begin
              if (idx_q != (len_q - 8'd1)) begin
                idx_d   = idx_q + 8'd1;
                addr_d  = idx_q + 8'd1;
                state_d = StFetch;
              end else begin
                state_d = StCrcLo;
              end
            end
            SelCrcLo: state_d = StCrcHi;
            default: begin
              cnt_d   = 32'd0;
              state_d = StGap;
            end
          endcase
        end else if (cnt_q == TmoLast) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      StCrcLo: begin
        if (!crc_busy) begin
          tx_data_d  = crc_val[7:0];
          crc_out_d  = crc_val;
          sel_d      = SelCrcLo;
          tx_start_d = 1'b1;
          cnt_d      = 32'd0;
          state_d    = StStart;
        end
      end
      StCrcHi: begin
        tx_data_d  = crc_out_q[15:8];
        sel_d      = SelCrcHi;
        tx_start_d = 1'b1;
        cnt_d      = 32'd0;
        state_d    = StStart;
      end
      StGap: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == GapLast) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      sel_q      <= SelData;
      len_q      <= 8'd0;
      idx_q      <= 8'd0;
      addr_q     <= 8'd0;
      tx_data_q  <= 8'd0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      crc_out_q  <= 16'd0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      crc_out_q  <= crc_out_d;
      cnt_q      <= cnt_d;
    end
  end

  assign buf_rd_addr = addr_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign crc_out     = crc_out_q;

endmodule

// File: tb/tb_modbus_tx_frame_ctrl.sv
// Directed bench for modbus_tx_frame_ctrl with a buffer RAM and byte-transmitter model.
module tb_modbus_tx_frame_ctrl;

  localparam int unsigned CLK_F  = 192000;
  localparam int unsigned BAUD   = 19200;
  localparam int unsigned BPS    = CLK_F / BAUD;                 // 10
  localparam int unsigned GAP    = (BAUD > 19200) ? CLK_F / 1000 * 7 / 4 : BPS * 39;  // 390
  localparam int unsigned TMO    = BPS * 12 + 16;                // 136
  localparam int          TX_DLY = 40;

  logic        clk, rst_n, frame_start, tx_done, tx_start, busy, frame_done, frame_err;
  logic [7:0]  frame_len, buf_rd_addr, buf_rd_data, tx_data;
  logic [15:0] crc_out;
  logic [7:0]  mem [256];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] byte_q [$];
  int         width_q [$];
  int done_cnt, err_cnt, done_cyc, err_cyc, rise_cyc, cur_w, txdone_edge;
  int nbytes, withhold_byte, stable_bad;
  logic prev_start, busy_at_done;

  logic [7:0] exp1 [8];
  logic [7:0] exp2 [8];

  modbus_tx_frame_ctrl #(
    .CLK_FREQ  (CLK_F),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .frame_start (frame_start),
    .frame_len   (frame_len),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .crc_out     (crc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Synchronous-read frame buffer.
  always @(posedge clk) buf_rd_data <= mem[buf_rd_addr];

  // Line monitor.
  initial begin
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !prev_start) begin
        byte_q.push_back(tx_data);
        rise_cyc = cyc;
        cur_w    = 1;
      end else if (tx_start) begin
        cur_w = cur_w + 1;
      end
      if (!tx_start && prev_start) width_q.push_back(cur_w);
      if (frame_done) begin
        done_cnt     = done_cnt + 1;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (frame_err) begin
        err_cnt = err_cnt + 1;
        err_cyc = cyc;
      end
      prev_start = tx_start;
    end
  end

  // Byte-transmitter model: tx_done TX_DLY cycles after each tx_start rise.
  initial begin
    logic       m_prev, aborted;
    logic [7:0] d;
    tx_done = 1'b0;
    m_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !m_prev && rst_n) begin
        d      = tx_data;
        nbytes = nbytes + 1;
        if (nbytes != withhold_byte) begin
          aborted = 1'b0;
          for (int i = 0; i < TX_DLY; i++) begin
            @(negedge clk);
            if (!rst_n) aborted = 1'b1;
          end
          if (!aborted) begin
            if (tx_data !== d) stable_bad = stable_bad + 1;
            tx_done     = 1'b1;
            txdone_edge = cyc + 1;
            @(negedge clk);
            tx_done = 1'b0;
          end
        end
      end
      m_prev = tx_start;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (got === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    byte_q.delete();
    width_q.delete();
    done_cnt   = 0;
    err_cnt    = 0;
    nbytes     = 0;
    stable_bad = 0;
  endtask

  task automatic load_buf(input logic [7:0] last);
    mem[0] = 8'h01; mem[1] = 8'h03; mem[2] = 8'h00;
    mem[3] = 8'h00; mem[4] = 8'h00; mem[5] = last;
  endtask

  task automatic pulse_start(input logic [7:0] len);
    @(negedge clk);
    frame_start = 1'b1;
    frame_len   = len;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int i;
    i = 0;
    while (done_cnt == 0 && err_cnt == 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(i < 3000), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, " tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, " buf_rd_addr"}, 32'(buf_rd_addr), 32'd0);
    chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, " frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, " crc_out"}, 32'(crc_out), 32'd0);
  endtask

  task automatic check_good_frame(input string tag, input logic [15:0] crc_exp,
                                  input logic [7:0] expb [8]);
    chk({tag, " byte count"}, 32'(byte_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < byte_q.size()) chk($sformatf("%s byte%0d", tag, i), 32'(byte_q[i]),
                                 32'(expb[i]));
    end
    chk({tag, " start widths"}, 32'(width_q.size()), 32'd8);
    for (int i = 0; i < width_q.size(); i++) begin
      chk($sformatf("%s width%0d", tag, i), 32'(width_q[i]), 32'd2);
    end
    chk({tag, " crc_out"}, 32'(crc_out), 32'(crc_exp));
    chk({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, " err pulses"}, 32'(err_cnt), 32'd0);
    chk({tag, " gap"}, 32'(done_cyc - txdone_edge), 32'(GAP));
    chk({tag, " busy at done"}, 32'(busy_at_done), 32'd0);
    chk({tag, " tx_data stable"}, 32'(stable_bad), 32'd0);
  endtask

  initial begin
    exp1 = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
    exp2 = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    rst_n         = 1'b0;
    frame_start   = 1'b0;
    frame_len     = 8'd0;
    withhold_byte = 0;
    clear_log();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1 with a frame_start while busy.
    load_buf(8'h0A);
    clear_log();
    pulse_start(8'd6);
    chk("busy after start", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    pulse_start(8'd3);
    wait_end("frame1 end");
    repeat (20) @(negedge clk);
    check_good_frame("frame1", 16'hCDC5, exp1);

    // Zero-length request is ignored.
    clear_log();
    pulse_start(8'd0);
    chk("len0 busy", 32'(busy), 32'd0);
    repeat (60) @(negedge clk);
    chk("len0 bytes", 32'(byte_q.size()), 32'd0);
    chk("len0 pulses", 32'(done_cnt + err_cnt), 32'd0);
    chk("len0 crc held", 32'(crc_out), 32'hCDC5);

    // Frame 2.
    load_buf(8'h01);
    clear_log();
    pulse_start(8'd6);
    wait_end("frame2 end");
    repeat (5) @(negedge clk);
    check_good_frame("frame2", 16'h0A84, exp2);

    // Watchdog: transmitter never finishes byte 3.
    clear_log();
    withhold_byte = 3;
    pulse_start(8'd6);
    wait_end("wdog end");
    repeat (5) @(negedge clk);
    chk("wdog err pulses", 32'(err_cnt), 32'd1);
    chk("wdog done pulses", 32'(done_cnt), 32'd0);
    chk("wdog timing", 32'(err_cyc - rise_cyc), 32'(TMO));
    chk("wdog busy", 32'(busy), 32'd0);
    chk("wdog bytes", 32'(byte_q.size()), 32'd3);
    withhold_byte = 0;
    load_buf(8'h0A);
    clear_log();
    pulse_start(8'd6);
    wait_end("post-wdog end");
    repeat (5) @(negedge clk);
    check_good_frame("post-wdog", 16'hCDC5, exp1);

    // Asynchronous reset during byte 2.
    clear_log();
    pulse_start(8'd6);
    begin
      int i;
      i = 0;
      while (byte_q.size() < 2 && i < 1000) begin
        @(negedge clk);
        i++;
      end
      chk("reset-test reach byte2", 32'(i < 1000), 32'd1);
    end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (TX_DLY + 20) @(negedge clk);
    chk("reset no pulses", 32'(done_cnt + err_cnt), 32'd0);
    load_buf(8'h01);
    clear_log();
    pulse_start(8'd6);
    wait_end("post-reset end");
    repeat (5) @(negedge clk);
    check_good_frame("post-reset", 16'h0A84, exp2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
